q_update_pipe: RTL and testbench
================================

Q_UPDATE_PIPE -- requirements
Module: q_update_pipe

Interface
REQ-001 Parameter ADDR_W, default 8: width of the state-action address carried with each update.
REQ-002 Port clk, input, 1: single clock; all state changes occur on its rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-low reset.
REQ-004 Port in_valid, input, 1: an update request is present this cycle.
REQ-005 Port in_ready, output, 1: the block accepts the request this cycle; this is combinational.
REQ-006 Port in_addr, input, ADDR_W: state-action index of the request.
REQ-007 Port R, input, 32: reward from the reward decider, signed Q16.16.
REQ-008 Port Q_sa, input, 32: current Q(s,a), signed Q16.16.
REQ-009 Port Qmax_next, input, 32: max Q of the next state, signed Q16.16.
REQ-010 Port alpha, input, 16: learning rate, unsigned Q0.16 (value/65536).
REQ-011 Port gamma, input, 16: discount factor, unsigned Q0.16.
REQ-012 Port out_valid, output, 1: Q_new and out_addr are valid this cycle; this is a one-cycle pulse per update.
REQ-013 Port out_addr, output, ADDR_W: address for the Q-table write-back.
REQ-014 Port Q_new, output, 32: updated Q value, signed Q16.16.
REQ-015 Port update_cnt, output, 16: count of accepted updates.

Function
REQ-016 A transfer occurs on a rising edge where in_valid=1 and in_ready=1; all inputs are sampled only at that edge.
REQ-017 Stage 1 SHALL register t1 = (Qmax_next * gamma) >>> 16, using a signed-by-unsigned 48-bit product with an arithmetic shift, truncated to 32 bits.
REQ-018 Stage 2 SHALL register t2 = R + t1 - Q_sa, computed at 34 bits and then reduced to 32 bits (see REQ-030).
REQ-019 Stage 3 SHALL register t3 = (t2 * alpha) >>> 16, with the same width rules as REQ-017.
REQ-020 Stage 4 (the output register) SHALL hold Q_new = Q_sa + t3, computed at 33 bits and then reduced to 32 bits.
REQ-021 Q_sa, address and valid travel with their update through every stage; the pipeline never stalls internally.
REQ-022 Latency: a transfer at edge k gives out_valid=1 in the cycle after edge k+4, cleared at edge k+5 unless another update is completing.
REQ-023 in_ready SHALL be 0 when in_valid=1 and in_addr equals the address of any valid stage 1–4; otherwise in_ready SHALL be 1.
REQ-024 A back-to-back update to the same address is therefore accepted no earlier than edge k+5.
REQ-025 Distinct addresses SHALL be accepted every cycle, giving a throughput of one update per clock.
REQ-026 update_cnt SHALL increment by 1 per transfer and wrap from 0xFFFF to 0x0000.
REQ-027 When a transfer and an output occur in the same cycle, both SHALL be handled; there is no priority conflict.

Reset
REQ-028 While rst=0, all stage valids, out_valid, out_addr, Q_new and update_cnt SHALL be 0 and in_ready SHALL be 1; the reset acts asynchronously.
REQ-029 An assertion of rst mid-operation SHALL discard all in-flight updates, and no out_valid pulse for them SHALL appear after release.

Configuration
REQ-030 With macro Q_SAT_EN defined, t2 and Q_new SHALL saturate to 0x7FFFFFFF or 0x80000000 on signed overflow.
REQ-031 Without Q_SAT_EN, t2 and Q_new SHALL keep the low 32 bits, wrapping two's-complement.
REQ-032 t1 and t3 cannot overflow and are unaffected by Q_SAT_EN.

Verification
REQ-033 Nominal case: R=0x00010000, Qmax_next=0x00020000, Q_sa=0x00008000, gamma=0x8000, alpha=0x8000 -> Q_new=0x00014000, out_valid exactly 4 edges after acceptance.
REQ-034 Throughput: addresses 1,2,3,4,5 issued on consecutive cycles -> in_ready stays 1, five consecutive out_valid pulses, update_cnt=5.
REQ-035 Hazard: address 7 issued twice back-to-back -> in_ready=0 for the second request until edge k+5, then the second request is accepted.
REQ-036 Saturation: Q_sa=0x70000000, R=0x7FFFFFFF, Qmax_next=0x7FFFFFFF, gamma=0xFFFF, alpha=0xFFFF -> Q_new=0x7FFFFFFF with Q_SAT_EN; Q_new differs from 0x7FFFFFFF without it.
REQ-037 Reset mid-flight: rst=0 two cycles after a transfer -> no out_valid afterwards, update_cnt=0, in_ready=1.
REQ-038 Counter wrap: 65536 transfers -> update_cnt returns to 0x0000.

Source files
------------

// File: rtl/q_update_pipe.sv
// Pipelined Q-learning update: Q_new = Q_sa + alpha*(R + gamma*Qmax_next - Q_sa).
// Define Q_SAT_EN to saturate t2 and Q_new on signed overflow; otherwise they wrap.
module q_update_pipe #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       R,
  input  logic [31:0]       Q_sa,
  input  logic [31:0]       Qmax_next,
  input  logic [15:0]       alpha,
  input  logic [15:0]       gamma,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       Q_new,
  output logic [15:0]       update_cnt
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned FRAC_W = 16;
  localparam int unsigned MUL_W  = DATA_W + FRAC_W + 1;
  localparam int unsigned SUM_W  = DATA_W + 2;
  localparam int unsigned ACC_W  = DATA_W + 1;
  localparam int unsigned CNT_W  = 16;

  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(64'sh000000007FFFFFFF);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-64'sh0000000080000000);

  // Signed Q16.16 times unsigned Q0.16, arithmetic shift back to Q16.16.
  function automatic logic [DATA_W-1:0] mul_frac(input logic [DATA_W-1:0] a,
                                                 input logic [FRAC_W-1:0] f);
    logic signed [MUL_W-1:0] p;
    p = MUL_W'($signed(a)) * MUL_W'($signed({1'b0, f}));
    return DATA_W'(p >>> FRAC_W);
  endfunction

  // Reduce a wide signed sum to 32 bits: saturate or wrap.
  function automatic logic [DATA_W-1:0] reduce(input logic signed [SUM_W-1:0] v);
`ifdef Q_SAT_EN
    if (v > SAT_MAX) return 32'h7FFF_FFFF;
    if (v < SAT_MIN) return 32'h8000_0000;
    return DATA_W'(v);
`else
    return DATA_W'(v);
`endif
  endfunction

  // Capture stage: raw operands
  logic              cap_vld_q,   cap_vld_d;
  logic [ADDR_W-1:0] cap_addr_q,  cap_addr_d;
  logic [DATA_W-1:0] cap_r_q,     cap_r_d;
  logic [DATA_W-1:0] cap_qsa_q,   cap_qsa_d;
  logic [DATA_W-1:0] cap_qmax_q,  cap_qmax_d;
  logic [FRAC_W-1:0] cap_alpha_q, cap_alpha_d;
  logic [FRAC_W-1:0] cap_gamma_q, cap_gamma_d;
  // t1 stage
  logic              s1_vld_q,    s1_vld_d;
  logic [ADDR_W-1:0] s1_addr_q,   s1_addr_d;
  logic [DATA_W-1:0] s1_r_q,      s1_r_d;
  logic [DATA_W-1:0] s1_qsa_q,    s1_qsa_d;
  logic [FRAC_W-1:0] s1_alpha_q,  s1_alpha_d;
  logic [DATA_W-1:0] s1_t1_q,     s1_t1_d;
  // t2 stage
  logic              s2_vld_q,    s2_vld_d;
  logic [ADDR_W-1:0] s2_addr_q,   s2_addr_d;
  logic [DATA_W-1:0] s2_qsa_q,    s2_qsa_d;
  logic [FRAC_W-1:0] s2_alpha_q,  s2_alpha_d;
  logic [DATA_W-1:0] s2_t2_q,     s2_t2_d;
  // t3 stage
  logic              s3_vld_q,    s3_vld_d;
  logic [ADDR_W-1:0] s3_addr_q,   s3_addr_d;
  logic [DATA_W-1:0] s3_qsa_q,    s3_qsa_d;
  logic [DATA_W-1:0] s3_t3_q,     s3_t3_d;
  // Output stage and counter
  logic              out_vld_q,   out_vld_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [DATA_W-1:0] qnew_q,      qnew_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  logic                    fire;
  logic                    hazard;
  logic signed [SUM_W-1:0] t2_sum;
  logic signed [ACC_W-1:0] qn_sum;

  // The output stage is not a hazard: its write-back lands on the edge a new request is accepted.
  always_comb begin
    hazard = (cap_vld_q && (cap_addr_q == in_addr)) ||
             (s1_vld_q  && (s1_addr_q  == in_addr)) ||
             (s2_vld_q  && (s2_addr_q  == in_addr)) ||
             (s3_vld_q  && (s3_addr_q  == in_addr));
    in_ready = !(in_valid && hazard);
    fire     = in_valid && in_ready;
  end

  always_comb begin
    cap_vld_d   = fire;
    cap_addr_d  = cap_addr_q;
    cap_r_d     = cap_r_q;
    cap_qsa_d   = cap_qsa_q;
    cap_qmax_d  = cap_qmax_q;
    cap_alpha_d = cap_alpha_q;
    cap_gamma_d = cap_gamma_q;
    s1_vld_d    = cap_vld_q;
    s1_addr_d   = s1_addr_q;
    s1_r_d      = s1_r_q;
    s1_qsa_d    = s1_qsa_q;
    s1_alpha_d  = s1_alpha_q;
    s1_t1_d     = s1_t1_q;
    s2_vld_d    = s1_vld_q;
    s2_addr_d   = s2_addr_q;
    s2_qsa_d    = s2_qsa_q;
    s2_alpha_d  = s2_alpha_q;
    s2_t2_d     = s2_t2_q;
    s3_vld_d    = s2_vld_q;
    s3_addr_d   = s3_addr_q;
    s3_qsa_d    = s3_qsa_q;
    s3_t3_d     = s3_t3_q;
    out_vld_d   = s3_vld_q;
    out_addr_d  = out_addr_q;
    qnew_d      = qnew_q;
    cnt_d       = cnt_q;

    t2_sum = SUM_W'($signed(s1_r_q)) + SUM_W'($signed(s1_t1_q)) - SUM_W'($signed(s1_qsa_q));
    qn_sum = ACC_W'($signed(s3_qsa_q)) + ACC_W'($signed(s3_t3_q));

    if (fire) begin
      cap_addr_d  = in_addr;
      cap_r_d     = R;
      cap_qsa_d   = Q_sa;
      cap_qmax_d  = Qmax_next;
      cap_alpha_d = alpha;
      cap_gamma_d = gamma;
      cnt_d       = cnt_q + CNT_W'(1);
    end
    if (cap_vld_q) begin
      s1_addr_d  = cap_addr_q;
      s1_r_d     = cap_r_q;
      s1_qsa_d   = cap_qsa_q;
      s1_alpha_d = cap_alpha_q;
      s1_t1_d    = mul_frac(cap_qmax_q, cap_gamma_q);
    end
    if (s1_vld_q) begin
      s2_addr_d  = s1_addr_q;
      s2_qsa_d   = s1_qsa_q;
      s2_alpha_d = s1_alpha_q;
      s2_t2_d    = reduce(t2_sum);
    end
    if (s2_vld_q) begin
      s3_addr_d = s2_addr_q;
      s3_qsa_d  = s2_qsa_q;
      s3_t3_d   = mul_frac(s2_t2_q, s2_alpha_q);
    end
    if (s3_vld_q) begin
      out_addr_d = s3_addr_q;
      qnew_d     = reduce(SUM_W'(qn_sum));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_vld_q   <= 1'b0;
      cap_addr_q  <= '0;
      cap_r_q     <= '0;
      cap_qsa_q   <= '0;
      cap_qmax_q  <= '0;
      cap_alpha_q <= '0;
      cap_gamma_q <= '0;
      s1_vld_q    <= 1'b0;
      s1_addr_q   <= '0;
      s1_r_q      <= '0;
      s1_qsa_q    <= '0;
      s1_alpha_q  <= '0;
      s1_t1_q     <= '0;
      s2_vld_q    <= 1'b0;
      s2_addr_q   <= '0;
      s2_qsa_q    <= '0;
      s2_alpha_q  <= '0;
      s2_t2_q     <= '0;
      s3_vld_q    <= 1'b0;
      s3_addr_q   <= '0;
      s3_qsa_q    <= '0;
      s3_t3_q     <= '0;
      out_vld_q   <= 1'b0;
      out_addr_q  <= '0;
      qnew_q      <= '0;
      cnt_q       <= '0;
    end else begin
      cap_vld_q   <= cap_vld_d;
      cap_addr_q  <= cap_addr_d;
      cap_r_q     <= cap_r_d;
      cap_qsa_q   <= cap_qsa_d;
      cap_qmax_q  <= cap_qmax_d;
      cap_alpha_q <= cap_alpha_d;
      cap_gamma_q <= cap_gamma_d;
      s1_vld_q    <= s1_vld_d;
      s1_addr_q   <= s1_addr_d;
      s1_r_q      <= s1_r_d;
      s1_qsa_q    <= s1_qsa_d;
      s1_alpha_q  <= s1_alpha_d;
      s1_t1_q     <= s1_t1_d;
      s2_vld_q    <= s2_vld_d;
      s2_addr_q   <= s2_addr_d;
      s2_qsa_q    <= s2_qsa_d;
      s2_alpha_q  <= s2_alpha_d;
      s2_t2_q     <= s2_t2_d;
      s3_vld_q    <= s3_vld_d;
      s3_addr_q   <= s3_addr_d;
      s3_qsa_q    <= s3_qsa_d;
      s3_t3_q     <= s3_t3_d;
      out_vld_q   <= out_vld_d;
      out_addr_q  <= out_addr_d;
      qnew_q      <= qnew_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = out_vld_q;
  assign out_addr   = out_addr_q;
  assign Q_new      = qnew_q;
  assign update_cnt = cnt_q;

endmodule

// File: tb/tb_q_update_pipe.sv
// Scoreboard bench for q_update_pipe: directed vectors, queue of expected write-backs.
module tb_q_update_pipe;

  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       R, Q_sa, Qmax_next;
  logic [15:0]       alpha, gamma;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       Q_new;
  logic [15:0]       update_cnt;

  q_update_pipe #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .R(R), .Q_sa(Q_sa), .Qmax_next(Qmax_next), .alpha(alpha), .gamma(gamma),
    .out_valid(out_valid), .out_addr(out_addr), .Q_new(Q_new), .update_cnt(update_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       q;
    int                edge_n;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef Q_SAT_EN
  localparam logic [31:0] SAT_EXP = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] SAT_EXP = 32'hFFFF_EFFE;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: addr 0x%02h Q_new 0x%08h at edge %0d, expected no output",
                 out_addr, Q_new, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_addr", 32'(out_addr), 32'(mon_e.addr));
        chk("Q_new", Q_new, mon_e.q);
        chk("out_edge", 32'(cyc), 32'(mon_e.edge_n));
      end
    end
  end

  // Present a request, wait (bounded) for acceptance, queue the expected result.
  task automatic xfer(input logic [ADDR_W-1:0] a, input logic [31:0] r, input logic [31:0] qsa,
                      input logic [31:0] qmx, input logic [15:0] al, input logic [15:0] ga,
                      input logic [31:0] expq, output int acc_edge);
    int   tries;
    exp_t ent;
    tries    = 0;
    acc_edge = -1;
    @(negedge clk);
    in_valid = 1'b1; in_addr = a; R = r; Q_sa = qsa; Qmax_next = qmx; alpha = al; gamma = ga;
    forever begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        acc_edge   = cyc;
        ent.addr   = a;
        ent.q      = expq;
        ent.edge_n = cyc + 4;
        exp_q.push_back(ent);
        break;
      end
      tries++;
      if (tries > 16) begin
        n_cmp++;
        n_err++;
        $display("FAIL xfer_timeout: addr 0x%02h never accepted, expected acceptance", a);
        in_valid = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  int   e0, e1, e2, e3, e4, ek;
  exp_t hz;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_addr = '0;
    R = '0; Q_sa = '0; Qmax_next = '0; alpha = '0; gamma = '0;

    // Reset state
    #3;
    in_valid = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_Q_new", Q_new, 32'd0);
    chk("rst_update_cnt", 32'(update_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Nominal update
    xfer(8'h10, 32'h0001_0000, 32'h0000_8000, 32'h0002_0000, 16'h8000, 16'h8000, 32'h0001_4000, e0);
    drain();
    chk("cnt_nominal", 32'(update_cnt), 32'd1);

    // Throughput: five distinct addresses on consecutive edges
    xfer(8'd1, 32'h0001_0000, 32'h0000_8000, 32'h0002_0000, 16'h8000, 16'h8000, 32'h0001_4000, e0);
    xfer(8'd2, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 16'h4000, 16'h0000, 32'h0000_C000, e1);
    xfer(8'd3, 32'hFFFF_0000, 32'h0003_0000, 32'h0004_0000, 16'hFFFF, 16'h4000, 32'h0000_0003, e2);
    xfer(8'd4, 32'h0000_0001, 32'h1234_5678, 32'h0000_0001, 16'h0000, 16'h0001, 32'h1234_5678, e3);
    xfer(8'd5, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 16'h8000, 16'h8000, 32'hFFFF_FFFF, e4);
    chk("tp_gap1", 32'(e1 - e0), 32'd1);
    chk("tp_gap2", 32'(e2 - e1), 32'd1);
    chk("tp_gap3", 32'(e3 - e2), 32'd1);
    chk("tp_gap4", 32'(e4 - e3), 32'd1);
    chk("cnt_tp", 32'(update_cnt), 32'd6);
    drain();

    // Same-address hazard
    xfer(8'd7, 32'h0001_0000, 32'h0000_8000, 32'h0002_0000, 16'h8000, 16'h8000, 32'h0001_4000, ek);
    in_addr = 8'd7;
    #1;
    chk("hz_idle_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b1; in_addr = 8'd7;
    R = 32'h0; Q_sa = 32'h0001_0000; Qmax_next = 32'h0; alpha = 16'h4000; gamma = 16'h0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hz_blocked", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("hz_release", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("hz_accept_edge", 32'(cyc - ek), 32'd5);
    hz.addr = 8'd7; hz.q = 32'h0000_C000; hz.edge_n = cyc + 4;
    exp_q.push_back(hz);
    drain();

    // Overflow: saturates with Q_SAT_EN, wraps otherwise
    xfer(8'h20, 32'h7FFF_FFFF, 32'h7000_0000, 32'h7FFF_FFFF, 16'hFFFF, 16'hFFFF, SAT_EXP, e0);
    drain();

    // Reset two cycles after a transfer discards it
    xfer(8'h30, 32'h0001_0000, 32'h0000_8000, 32'h0002_0000, 16'h8000, 16'h8000, 32'h0001_4000, e0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_cnt", 32'(update_cnt), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_cnt", 32'(update_cnt), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // Counter wrap
    for (int i = 0; i < 65535; i++)
      xfer(ADDR_W'(i), 32'h0001_0000, 32'h0000_8000, 32'h0002_0000, 16'h8000, 16'h8000,
           32'h0001_4000, e0);
    chk("cnt_ffff", 32'(update_cnt), 32'h0000_FFFF);
    xfer(8'hAA, 32'h0001_0000, 32'h0000_8000, 32'h0002_0000, 16'h8000, 16'h8000, 32'h0001_4000, e0);
    chk("cnt_wrap", 32'(update_cnt), 32'h0000_0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
